// File: rtl/dmem_stall_responder.sv
// Stalling data-memory responder: holds the core for LATENCY cycles per access,
// then completes with byte-lane stores or sign/zero-extended loads.
module dmem_stall_responder #(
  parameter int ADDR_WIDTH = 14,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [2:0]            access_mode,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  stall,
  output logic [31:0]           rdata,
  output logic                  ack,
  output logic                  err
);

  localparam int WORD_AW = ADDR_WIDTH - 2;
  localparam int DEPTH   = 1 << WORD_AW;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [2:0]              mode_q, mode_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;

  logic [31:0]             mem [DEPTH];

  logic                    eff_we;
  logic [2:0]              eff_mode;
  logic [ADDR_WIDTH-1:0]   eff_addr;
  logic [31:0]             eff_wdata;
  logic                    acc_err;
  logic [31:0]             rd_word;
  logic                    commit;
  logic                    mem_wr;
  logic [3:0]              wr_be;
  logic [31:0]             wr_lanes;
  logic [WORD_AW-1:0]      wr_idx;

  function automatic logic access_error(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] lo);
    logic bad_f3;
    logic misal;
    if (is_store) bad_f3 = f3[2] | (f3[1:0] == 2'b11);
    else          bad_f3 = (f3[1:0] == 2'b11) | (f3 == 3'b110);
    misal = ((f3[1:0] == 2'b01) & lo[0]) | ((f3[1:0] == 2'b10) & (lo != 2'b00));
    return bad_f3 | misal;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // With LATENCY=1 the access completes on its accept edge, so IDLE uses the live inputs
  always_comb begin
    if (state_q == IDLE) begin
      eff_we    = we;
      eff_mode  = access_mode;
      eff_addr  = addr;
      eff_wdata = wdata;
    end else begin
      eff_we    = we_q;
      eff_mode  = mode_q;
      eff_addr  = addr_q;
      eff_wdata = wdata_q;
    end
  end

  assign acc_err  = access_error(eff_we, eff_mode, eff_addr[1:0]);
  assign wr_idx   = eff_addr[ADDR_WIDTH-1:2];
  assign rd_word  = mem[wr_idx];
  assign wr_be    = store_be(eff_mode, eff_addr[1:0]);
  assign wr_lanes = store_lanes(eff_mode, eff_wdata);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    stall   = 1'b0;
    commit  = 1'b0;
    mem_wr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          stall   = 1'b1;
          we_d    = we;
          mode_d  = access_mode;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = DONE;
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == DONE && state_q != DONE) begin
      commit = 1'b1;
      ack_d  = 1'b1;
      err_d  = acc_err;
      if (acc_err)      rdata_d = '0;
      else if (!eff_we) rdata_d = load_extract(rd_word, eff_mode, eff_addr[1:0]);
    end
    mem_wr = commit & eff_we & ~acc_err & ~rst;
    if (rst) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    mode_q  <= mode_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) mem[wr_idx][8*k +: 8] <= wr_lanes[8*k +: 8];
      end
    end
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dmem_stall_responder.sv
// Bench for dmem_stall_responder: byte-array reference model checked every cycle,
// plus directed accesses with literal expected results (LATENCY=2 and LATENCY=1).
module tb_dmem_stall_responder;

  localparam int AW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [1:0]           req, we, stall, ack, err;
  logic [1:0][2:0]      mode;
  logic [1:0][AW-1:0]   addr;
  logic [1:0][31:0]     wdata, rdata;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  dmem_stall_responder #(.ADDR_WIDTH(AW), .LATENCY(2)) u0 (
    .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .access_mode(mode[0]),
    .addr(addr[0]), .wdata(wdata[0]), .stall(stall[0]), .rdata(rdata[0]),
    .ack(ack[0]), .err(err[0]));

  dmem_stall_responder #(.ADDR_WIDTH(AW), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .access_mode(mode[1]),
    .addr(addr[1]), .wdata(wdata[1]), .stall(stall[1]), .rdata(rdata[1]),
    .ack(ack[1]), .err(err[1]));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Reference model: byte-addressed memory, phase = cycles since the accept edge
  logic [7:0]  mmem [2][1 << AW];
  int          phase [2];
  logic [31:0] exp_rd [2];
  logic        exp_er [2];
  logic        m_we [2];
  int          m_mode [2];
  int          m_addr [2];
  logic [31:0] m_wdata [2];

  function automatic bit model_err(input bit st, input int f3, input int a);
    bit legal;
    int sz;
    if (st) legal = (f3 <= 2);
    else    legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    sz = 1 << (f3 % 4);
    return !legal || (a % sz != 0);
  endfunction

  task automatic model_complete(input int i);
    int a, sz;
    logic [31:0] v;
    a  = m_addr[i];
    sz = 1 << (m_mode[i] % 4);
    exp_er[i] = model_err(m_we[i], m_mode[i], a);
    if (exp_er[i]) begin
      exp_rd[i] = 32'd0;
    end else if (m_we[i]) begin
      for (int k = 0; k < sz; k++) mmem[i][a + k] = m_wdata[i][8*k +: 8];
    end else begin
      v = 32'd0;
      for (int k = 0; k < sz; k++) v = v | (32'(mmem[i][a + k]) << (8 * k));
      if (m_mode[i] < 4 && sz < 4 && v[8*sz - 1]) v = v | (32'hFFFF_FFFF << (8 * sz));
      exp_rd[i] = v;
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        phase[i]  = 0;
        exp_rd[i] = 32'd0;
        exp_er[i] = 1'b0;
      end else if (phase[i] == 0) begin
        if (req[i]) begin
          m_we[i]    = we[i];
          m_mode[i]  = int'(mode[i]);
          m_addr[i]  = int'(addr[i]);
          m_wdata[i] = wdata[i];
          phase[i]   = 1;
          if (lat_of(i) == 1) model_complete(i);
        end
      end else if (phase[i] == lat_of(i)) begin
        phase[i] = 0;
      end else begin
        phase[i]++;
        if (phase[i] == lat_of(i)) model_complete(i);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic es, ea;
        es = !rst && ((phase[i] == 0) ? req[i] : (phase[i] < lat_of(i)));
        ea = (phase[i] == lat_of(i));
        chk($sformatf("u%0d_stall", i), stall[i], es);
        chk($sformatf("u%0d_ack", i), ack[i], ea);
        if (ea) chk($sformatf("u%0d_err", i), err[i], exp_er[i]);
        chk($sformatf("u%0d_rdata", i), rdata[i], exp_rd[i]);
      end
    end
  end

  task automatic access(input int i, input bit w, input logic [2:0] md, input logic [AW-1:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rdv, input bit exp_e,
                        input string nm);
    int n;
    bit got;
    @(posedge clk); #1;
    we[i] = w; mode[i] = md; addr[i] = a; wdata[i] = wd; req[i] = 1'b1;
    n = 0;
    got = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      got = ack[i];
    end
    chk({nm, "_ack"}, 32'(got), 32'd1);
    chk({nm, "_lat"}, n, lat_of(i));
    chk({nm, "_err"}, err[i], exp_e);
    chk({nm, "_rdata"}, rdata[i], exp_rdv);
    req[i] = 1'b0;
  endtask

  logic        l1w [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [2:0]  l1m [4] = '{3'b010, 3'b000, 3'b010, 3'b101};
  logic [13:0] l1a [4] = '{14'h100, 14'h101, 14'h100, 14'h102};
  logic [31:0] l1d [4] = '{32'hA5A5_0001, 32'h0000_007F, 32'd0, 32'd0};
  logic [31:0] l1x [4] = '{32'd0, 32'd0, 32'hA5A5_7F01, 32'h0000_A5A5};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit got;
    for (int i = 0; i < 2; i++) begin
      phase[i] = 0; exp_rd[i] = 0; exp_er[i] = 0;
      for (int b = 0; b < (1 << AW); b++) mmem[i][b] = 8'd0;
    end
    rst = 1'b1;
    req = 2'b11; we = 2'b00;
    mode[0] = 3'b010; mode[1] = 3'b010;
    addr[0] = 14'h010; addr[1] = 14'h010;
    wdata[0] = 32'd0; wdata[1] = 32'd0;

    repeat (2) begin
      @(posedge clk); #1;
      chk_en = 1;
      chk("rst_stall", stall[0], 0);
      chk("rst_ack", ack[0], 0);
      chk("rst_err", err[0], 0);
      chk("rst_rdata", rdata[0], 0);
    end
    rst = 1'b0;
    req = 2'b00;
    @(posedge clk); #1;
    chk("post_rst_ack", ack[0], 0);
    chk("post_rst_stall", stall[0], 0);

    access(0, 1, 3'b010, 14'h010, 32'hDEAD_BEEF, 32'h0000_0000, 0, "sw_010");
    access(0, 0, 3'b010, 14'h010, 32'd0,         32'hDEAD_BEEF, 0, "lw_010");
    access(0, 1, 3'b000, 14'h013, 32'h0000_0012, 32'hDEAD_BEEF, 0, "sb_013");
    access(0, 0, 3'b010, 14'h010, 32'd0,         32'h12AD_BEEF, 0, "lw_after_sb");
    access(0, 0, 3'b000, 14'h011, 32'd0,         32'hFFFF_FFBE, 0, "lb_011");
    access(0, 0, 3'b100, 14'h011, 32'd0,         32'h0000_00BE, 0, "lbu_011");
    access(0, 0, 3'b001, 14'h012, 32'd0,         32'h0000_12AD, 0, "lh_012");
    access(0, 0, 3'b101, 14'h010, 32'd0,         32'h0000_BEEF, 0, "lhu_010");
    access(0, 0, 3'b001, 14'h010, 32'd0,         32'hFFFF_BEEF, 0, "lh_010_neg");
    access(0, 0, 3'b010, 14'h012, 32'd0,         32'h0000_0000, 1, "lw_misal");
    access(0, 1, 3'b001, 14'h011, 32'h0000_FFFF, 32'h0000_0000, 1, "sh_misal");
    access(0, 0, 3'b010, 14'h010, 32'd0,         32'h12AD_BEEF, 0, "lw_after_sh_misal");
    access(0, 0, 3'b011, 14'h010, 32'd0,         32'h0000_0000, 1, "ld_f3_011");
    access(0, 1, 3'b100, 14'h010, 32'hFFFF_FFFF, 32'h0000_0000, 1, "st_f3_100");
    access(0, 0, 3'b010, 14'h010, 32'd0,         32'h12AD_BEEF, 0, "lw_after_bad_st");
    access(0, 1, 3'b001, 14'h012, 32'h0000_CAFE, 32'h12AD_BEEF, 0, "sh_012");
    access(0, 0, 3'b010, 14'h010, 32'd0,         32'hCAFE_BEEF, 0, "lw_after_sh");
    access(0, 1, 3'b010, 14'h3FFC, 32'h0123_4567, 32'hCAFE_BEEF, 0, "sw_top");
    access(0, 0, 3'b010, 14'h3FFC, 32'd0,         32'h0123_4567, 0, "lw_top");
    access(0, 0, 3'b000, 14'h3FFF, 32'd0,         32'h0000_0001, 0, "lb_top");
    access(0, 1, 3'b010, 14'h020, 32'h0000_0000, 32'h0000_0001, 0, "sw_020_zero");

    // Store interrupted by reset during its first BUSY cycle
    @(posedge clk); #1;
    we[0] = 1'b1; mode[0] = 3'b010; addr[0] = 14'h020; wdata[0] = 32'h0000_0055; req[0] = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_busy_stall", stall[0], 1);
    rst = 1'b1;
    req[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_stall", stall[0], 0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("rst_mid_no_ack", ack[0], 0);
    end
    access(0, 0, 3'b010, 14'h010, 32'd0, 32'hCAFE_BEEF, 0, "lw_010_after_rst");
    access(0, 0, 3'b010, 14'h020, 32'd0, 32'h0000_0000, 0, "lw_020_after_rst");

    // LATENCY=1 instance with req held high across four accesses
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      we[1] = l1w[k]; mode[1] = l1m[k]; addr[1] = l1a[k]; wdata[1] = l1d[k]; req[1] = 1'b1;
      n = 0;
      got = 0;
      while (!got && n < 20) begin
        @(posedge clk); #1;
        n++;
        got = ack[1];
      end
      chk("l1_ack", 32'(got), 32'd1);
      chk("l1_ack_spacing", n, (k == 0) ? 1 : 2);
      chk("l1_done_stall", stall[1], 0);
      chk("l1_err", err[1], 0);
      if (!l1w[k]) chk("l1_rdata", rdata[1], l1x[k]);
    end
    req[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
